// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   // Digits needed for a w-bit unsigned value.
   function automatic int unsigned nd_for_width(int unsigned w);
      return (w + (w - 4) / 3 + 4) / 4;
   endfunction

   // Counter wide enough for the largest supported input width.
   localparam int unsigned MaxW  = 32;
   localparam int unsigned CNT_W = $clog2(MaxW + 1);

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Input/output handshake bundle for bin2bcd_seq.
interface bin2bcd_seq_if #(
   parameter int unsigned W  = 18,
   parameter int unsigned ND = bin2bcd_pkg::nd_for_width(W)
);
   logic [W-1:0]    bin;
   logic            in_valid;
   logic            in_ready;
   logic [4*ND-1:0] bcd;
   logic            neg;
   logic [ND-1:0]   blank;
   logic            ovf;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output bin, in_valid, out_ready,
      input  in_ready, bcd, neg, blank, ovf, out_valid
   );

   modport slave (
      input  bin, in_valid, out_ready,
      output in_ready, bcd, neg, blank, ovf, out_valid
   );
endinterface

// File: rtl/bin2bcd_seq_dabble_adj.sv
// Add-3 correction applied to one BCD digit before each double-dabble shift.
module dabble_adj (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);
   assign d_o = (d_i >= 4'd5) ? 4'(d_i + 4'd3) : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, handshake on both sides,
// leading-zero blanking mask and overflow flag when ND is narrower than the input needs.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned W      = 18,
   parameter int unsigned ND     = nd_for_width(W),
   parameter bit          SIGNED = 1'b0
) (
   input logic          clk,
   input logic          reset_n,
   bin2bcd_seq_if.slave bus_io
);
   localparam logic [ND-1:0] BlankRst = ~ND'(1);

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]    sr_q, sr_d, sr_shift, mag;
   logic [4*ND-1:0] acc_q, acc_d, acc_adj, acc_shift;
   logic            ovf_acc_q, ovf_acc_d, sign_q, sign_d;
   logic [4*ND-1:0] bcd_q, bcd_d;
   logic [ND-1:0]   blank_q, blank_d, blank_next;
   logic            neg_q, neg_d, ovf_q, ovf_d;
   logic            in_neg, shift_out, last_shift, zero_run;
   logic            in_ready, out_valid;

   for (genvar g = 0; g < int'(ND); g++) begin : g_adj
      dabble_adj u_adj (
         .d_i(acc_q[4*g +: 4]),
         .d_o(acc_adj[4*g +: 4])
      );
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus_io.in_valid) state_d = StShift;
         StShift: if (last_shift) state_d = StDone;
         StDone:  if (bus_io.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   assign last_shift = (cnt_q == CNT_W'(1));
   assign in_neg     = SIGNED && bus_io.bin[W-1];
   // Two's-complement negate in W bits; the most negative input maps to 2^(W-1).
   assign mag        = in_neg ? (~bus_io.bin + W'(1)) : bus_io.bin;
   assign {shift_out, acc_shift, sr_shift} = {acc_adj, sr_q, 1'b0};

   always_comb begin
      zero_run      = 1'b1;
      blank_next    = '0;
      for (int i = int'(ND) - 1; i >= 1; i--) begin
         zero_run      = zero_run & (acc_shift[4*i +: 4] == 4'd0);
         blank_next[i] = zero_run;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
      sign_d    = sign_q;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      if (in_ready && bus_io.in_valid) begin
         sr_d      = mag;
         acc_d     = '0;
         ovf_acc_d = 1'b0;
         sign_d    = in_neg;
         cnt_d     = CNT_W'(W);
      end else if (state_q == StShift) begin
         sr_d      = sr_shift;
         acc_d     = acc_shift;
         ovf_acc_d = ovf_acc_q | shift_out;
         cnt_d     = cnt_q - CNT_W'(1);
         if (last_shift) begin
            bcd_d   = acc_shift;
            blank_d = blank_next;
            neg_d   = sign_q;
            ovf_d   = ovf_acc_q | shift_out;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         sr_q      <= '0;
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= BlankRst;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         acc_q     <= acc_d;
         ovf_acc_q <= ovf_acc_d;
         sign_q    <= sign_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid;
   assign bus_io.bcd       = bcd_q;
   assign bus_io.blank     = blank_q;
   assign bus_io.neg       = neg_q;
   assign bus_io.ovf       = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   bin2bcd_seq_if #(.W(18))         if18 ();
   bin2bcd_seq_if #(.W(8), .ND(3))  if_s8 ();
   bin2bcd_seq_if #(.W(8), .ND(2))  if_n2 ();

   // Both 8-bit instances see identical stimulus.
   logic [7:0] bin8;
   logic       vld8, rdy8;
   assign if_s8.bin       = bin8;
   assign if_s8.in_valid  = vld8;
   assign if_s8.out_ready = rdy8;
   assign if_n2.bin       = bin8;
   assign if_n2.in_valid  = vld8;
   assign if_n2.out_ready = rdy8;

   bin2bcd_seq #(.W(18)) u_dut18 (.clk(clk), .reset_n(reset_n), .bus_io(if18.slave));
   bin2bcd_seq #(.W(8), .ND(3), .SIGNED(1'b1)) u_dut_s8 (
      .clk(clk), .reset_n(reset_n), .bus_io(if_s8.slave));
   bin2bcd_seq #(.W(8), .ND(2)) u_dut_n2 (.clk(clk), .reset_n(reset_n), .bus_io(if_n2.slave));

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic longint pow10(int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic longint mag_of(longint v, int w, bit sgn);
      if (sgn && v[w-1]) return (longint'(1) << w) - v;
      return v;
   endfunction

   function automatic logic [63:0] ref_bcd(longint m, int nd);
      logic [63:0] r = '0;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_blank(longint m, int nd);
      logic [63:0] r = '0;
      longint t = m % pow10(nd);
      for (int i = 1; i < nd; i++) r[i] = (t / pow10(i) == 0);
      return r;
   endfunction

   task automatic wait_ready18(input string tag);
      int guard = 0;
      @(negedge clk);
      while (!if18.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_eq({tag, ".in_ready"}, if18.in_ready, 1);
   endtask

   task automatic run18(input logic [17:0] val, input string tag, output logic [23:0] bcd_o);
      int lat = 0;
      longint m = mag_of(longint'(val), 18, 1'b0);
      wait_ready18(tag);
      if18.bin = val;
      if18.in_valid = 1'b1;
      @(posedge clk);
      #1 if18.in_valid = 1'b0;
      if18.bin = 18'($urandom);
      while (!if18.out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      check_eq({tag, ".lat"}, lat, 18);
      check_eq({tag, ".bcd"}, if18.bcd, ref_bcd(m, 6));
      check_eq({tag, ".blank"}, if18.blank, ref_blank(m, 6));
      check_eq({tag, ".ovf"}, if18.ovf, m >= pow10(6));
      check_eq({tag, ".neg"}, if18.neg, 0);
      bcd_o = if18.bcd;
      @(negedge clk) if18.out_ready = 1'b1;
      @(posedge clk);
      #1 if18.out_ready = 1'b0;
      check_eq({tag, ".idle_rdy"}, if18.in_ready, 1);
      check_eq({tag, ".held_bcd"}, if18.bcd, ref_bcd(m, 6));
   endtask

   task automatic run8(input logic [7:0] val, input string tag);
      int lat = 0;
      int guard = 0;
      longint ms = mag_of(longint'(val), 8, 1'b1);
      longint mu = longint'(val);
      @(negedge clk);
      while (!if_s8.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      bin8 = val;
      vld8 = 1'b1;
      @(posedge clk);
      #1 vld8 = 1'b0;
      bin8 = 8'($urandom);
      while (!if_s8.out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      check_eq({tag, ".lat"}, lat, 8);
      check_eq({tag, ".s.bcd"}, if_s8.bcd, ref_bcd(ms, 3));
      check_eq({tag, ".s.blank"}, if_s8.blank, ref_blank(ms, 3));
      check_eq({tag, ".s.neg"}, if_s8.neg, val[7]);
      check_eq({tag, ".s.ovf"}, if_s8.ovf, 0);
      check_eq({tag, ".n.vld"}, if_n2.out_valid, 1);
      check_eq({tag, ".n.bcd"}, if_n2.bcd, ref_bcd(mu, 2));
      check_eq({tag, ".n.blank"}, if_n2.blank, ref_blank(mu, 2));
      check_eq({tag, ".n.ovf"}, if_n2.ovf, mu >= 100);
      @(negedge clk) rdy8 = 1'b1;
      @(posedge clk);
      #1 rdy8 = 1'b0;
   endtask

   logic [23:0] got;
   int          lat_bp;

   initial begin
      if18.bin = '0;
      if18.in_valid = 1'b0;
      if18.out_ready = 1'b0;
      bin8 = '0;
      vld8 = 1'b0;
      rdy8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      #1;
      check_eq("rst.in_ready", if18.in_ready, 1);
      check_eq("rst.out_valid", if18.out_valid, 0);
      check_eq("rst.bcd", if18.bcd, 0);
      check_eq("rst.blank", if18.blank, 6'b111110);
      check_eq("rst.neg_ovf", {if18.neg, if18.ovf}, 0);
      check_eq("rst.n2.blank", if_n2.blank, 2'b10);

      run18(18'd262143, "max", got);
      check_eq("max.const", got, 24'h262143);
      run18(18'd0, "zero", got);
      check_eq("zero.blank.const", if18.blank, 6'b111110);
      run18(18'd42, "d42", got);
      check_eq("d42.const", got, 24'h000042);
      check_eq("d42.blank.const", if18.blank, 6'b111100);

      run8(8'h80, "h80");
      check_eq("h80.const", if_s8.bcd, 12'h128);
      run8(8'hFF, "hFF");
      check_eq("hFF.const", {if_s8.neg, if_s8.bcd, if_n2.ovf, if_n2.bcd}, {1'b1, 12'h001, 1'b1, 8'h55});
      run8(8'h7F, "h7F");
      check_eq("h7F.const", {if_s8.neg, if_s8.bcd}, {1'b0, 12'h127});
      run8(8'd99, "d99");
      check_eq("d99.const", {if_n2.ovf, if_n2.bcd}, {1'b0, 8'h99});
      run8(8'd0, "z8");

      for (int i = 0; i < 20; i++) run18(18'($urandom), $sformatf("r18_%0d", i), got);
      for (int i = 0; i < 20; i++) run8(8'($urandom), $sformatf("r8_%0d", i));

      // Back-pressure: result held while out_ready is low, new requests ignored.
      wait_ready18("bp");
      if18.bin = 18'd123456;
      if18.in_valid = 1'b1;
      @(posedge clk);
      #1 if18.in_valid = 1'b0;
      lat_bp = 0;
      while (!if18.out_valid && lat_bp < 100) begin
         @(posedge clk);
         #1 lat_bp++;
      end
      check_eq("bp.lat", lat_bp, 18);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if18.bin = 18'($urandom);
         if18.in_valid = 1'b1;
         @(posedge clk);
         #1 if18.in_valid = 1'b0;
         check_eq("bp.vld", if18.out_valid, 1);
         check_eq("bp.in_ready", if18.in_ready, 0);
         check_eq("bp.bcd", if18.bcd, 24'h123456);
         check_eq("bp.blank", if18.blank, 6'b000000);
      end
      @(negedge clk) if18.out_ready = 1'b1;
      @(posedge clk);
      #1 if18.out_ready = 1'b0;
      check_eq("bp.release_vld", if18.out_valid, 0);
      check_eq("bp.release_rdy", if18.in_ready, 1);
      run18(18'd777, "bp_next", got);

      // Reset in the middle of a conversion aborts it.
      wait_ready18("mid");
      if18.bin = 18'd54321;
      if18.in_valid = 1'b1;
      @(posedge clk);
      #1 if18.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk) reset_n = 1'b0;
      #1;
      check_eq("mid.vld", if18.out_valid, 0);
      check_eq("mid.bcd", if18.bcd, 0);
      check_eq("mid.blank", if18.blank, 6'b111110);
      check_eq("mid.neg_ovf", {if18.neg, if18.ovf}, 0);
      @(negedge clk) reset_n = 1'b1;
      #1 check_eq("mid.in_ready", if18.in_ready, 1);
      run18(18'd1000, "after_rst", got);
      check_eq("after_rst.const", got, 24'h001000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
